// File: rtl/bspi_pkg.sv
// Shared BSPI definitions: default byte width and the pointer-difference level helper.
package bspi_pkg;

   localparam int BSPI_DW     = 8;
   // Widest pointer the level helper handles; FIFOs must keep AW+1 <= BSPI_PW_MAX.
   localparam int BSPI_PW_MAX = 16;

   function automatic logic [BSPI_PW_MAX-1:0] bspi_lvl(
      input logic [BSPI_PW_MAX-1:0] wp,
      input logic [BSPI_PW_MAX-1:0] rp,
      input int                     aw
   );
      logic [BSPI_PW_MAX-1:0] mask;
      mask = BSPI_PW_MAX'((1 << (aw + 1)) - 1);
      return (wp - rp) & mask;
   endfunction

endpackage

// File: rtl/bspi_sff_if.sv
// Byte-path FIFO bundle: producer/consumer requests towards the FIFO, status back.
interface bspi_sff_if
   import bspi_pkg::*;
#(
   parameter int DW = BSPI_DW,
   parameter int AW = 2
);
   logic          clr;
   logic          wen;
   logic [DW-1:0] wdt;
   logic          wfl;
   logic          ren;
   logic [DW-1:0] rdt;
   logic          rey;
   logic [AW:0]   lvl;
   logic          afl;
   logic          aey;
   logic          ovf;
   logic          udf;

   modport master (
      output clr, wen, wdt, ren,
      input  wfl, rdt, rey, lvl, afl, aey, ovf, udf
   );

   modport slave (
      input  clr, wen, wdt, ren,
      output wfl, rdt, rey, lvl, afl, aey, ovf, udf
   );
endinterface

// File: rtl/bspi_sff_mem.sv
// 2^AW x DW register array: one synchronous write port, one combinational read port, no reset.
module bspi_sff_mem #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          ck,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         always_ff @(posedge ck) begin
            if (we && (waddr == AW'(gi))) begin
               mem_q[gi] <= wdata;
            end
         end
      end
   endgenerate

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/bspi_sff.sv
// Single-clock BSPI byte FIFO with fill level, threshold flags, flush and sticky over/underflow.
module bspi_sff
   import bspi_pkg::*;
#(
   parameter int DW     = BSPI_DW,
   parameter int AW     = 2,
   parameter int AFL_TH = 3,
   parameter int AEY_TH = 1,
   parameter int FWFT   = 1
) (
   input  logic      ck,
   input  logic      rst,
   bspi_sff_if.slave bus
);
   localparam logic [BSPI_PW_MAX-1:0] AFL_V = BSPI_PW_MAX'(AFL_TH);
   localparam logic [BSPI_PW_MAX-1:0] AEY_V = BSPI_PW_MAX'(AEY_TH);
   localparam int                     PAD   = BSPI_PW_MAX - AW - 1;

   logic [AW:0]            wptr_q, wptr_d;
   logic [AW:0]            rptr_q, rptr_d;
   logic                   ovf_q, ovf_d;
   logic                   udf_q, udf_d;
   logic [BSPI_PW_MAX-1:0] lvl_w;
   logic                   full, empty;
   logic                   wr_acc, rd_acc;
   logic [DW-1:0]          mem_rdata;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign lvl_w = bspi_lvl({{PAD{1'b0}}, wptr_q}, {{PAD{1'b0}}, rptr_q}, AW);

   assign bus.wfl = full;
   assign bus.rey = empty;
   assign bus.lvl = lvl_w[AW:0];
   assign bus.afl = (lvl_w >= AFL_V);
   assign bus.aey = (lvl_w <= AEY_V);
   assign bus.ovf = ovf_q;
   assign bus.udf = udf_q;

   // Flush wins over both requests: nothing is written and no sticky flag is raised.
   always_comb begin
      wr_acc = bus.wen & ~full & ~bus.clr;
      rd_acc = bus.ren & ~empty & ~bus.clr;
      wptr_d = wptr_q + {{AW{1'b0}}, wr_acc};
      rptr_d = rptr_q + {{AW{1'b0}}, rd_acc};
      ovf_d  = ovf_q | (bus.wen & full);
      udf_d  = udf_q | (bus.ren & empty);
      if (bus.clr) begin
         wptr_d = '0;
         rptr_d = '0;
         ovf_d  = 1'b0;
         udf_d  = 1'b0;
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

   bspi_sff_mem #(
      .DW(DW),
      .AW(AW)
   ) u_mem (
      .ck   (ck),
      .we   (wr_acc),
      .waddr(wptr_q[AW-1:0]),
      .wdata(bus.wdt),
      .raddr(rptr_q[AW-1:0]),
      .rdata(mem_rdata)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         // Masked while empty so stale memory never leaks onto rdt.
         assign bus.rdt = empty ? '0 : mem_rdata;
      end else begin : g_rreg
         logic [DW-1:0] rdt_q, rdt_d;

         always_comb begin
            rdt_d = rdt_q;
            if (bus.clr) begin
               rdt_d = '0;
            end else if (rd_acc) begin
               rdt_d = mem_rdata;
            end
         end

         always_ff @(posedge ck or posedge rst) begin
            if (rst) begin
               rdt_q <= '0;
            end else begin
               rdt_q <= rdt_d;
            end
         end

         assign bus.rdt = rdt_q;
      end
   endgenerate

endmodule

// File: tb/tb_bspi_sff.sv
// Scenario bench for bspi_sff: FWFT and registered 4-deep byte FIFOs plus a 16-deep 16-bit FIFO.
module tb_bspi_sff;
   logic ck = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 ck = ~ck;

   bspi_sff_if #(.DW(8),  .AW(2)) if0 ();
   bspi_sff_if #(.DW(8),  .AW(2)) if1 ();
   bspi_sff_if #(.DW(16), .AW(4)) if2 ();

   bspi_sff #(.DW(8),  .AW(2), .AFL_TH(3),  .AEY_TH(1), .FWFT(1)) u0 (.ck(ck), .rst(rst), .bus(if0.slave));
   bspi_sff #(.DW(8),  .AW(2), .AFL_TH(3),  .AEY_TH(1), .FWFT(0)) u1 (.ck(ck), .rst(rst), .bus(if1.slave));
   bspi_sff #(.DW(16), .AW(4), .AFL_TH(14), .AEY_TH(2), .FWFT(1)) u2 (.ck(ck), .rst(rst), .bus(if2.slave));

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic pulse_clr0();
      if0.clr = 1'b1; step(); if0.clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_checks++; if (if0.wfl !== 1'b0)  begin n_errors++; $display("FAIL rst_wfl got %b want 0", if0.wfl); end
      n_checks++; if (if0.rey !== 1'b1)  begin n_errors++; $display("FAIL rst_rey got %b want 1", if0.rey); end
      n_checks++; if (if0.lvl !== 3'd0)  begin n_errors++; $display("FAIL rst_lvl got %0d want 0", if0.lvl); end
      n_checks++; if (if0.afl !== 1'b0)  begin n_errors++; $display("FAIL rst_afl got %b want 0", if0.afl); end
      n_checks++; if (if0.aey !== 1'b1)  begin n_errors++; $display("FAIL rst_aey got %b want 1", if0.aey); end
      n_checks++; if (if0.ovf !== 1'b0 || if0.udf !== 1'b0) begin n_errors++; $display("FAIL rst_sticky got ovf=%b udf=%b want 0 0", if0.ovf, if0.udf); end
      n_checks++; if (if0.rdt !== 8'h00) begin n_errors++; $display("FAIL rst_rdt0 got %h want 00", if0.rdt); end
      n_checks++; if (if1.rdt !== 8'h00) begin n_errors++; $display("FAIL rst_rdt1 got %h want 00", if1.rdt); end
      n_checks++; if (if2.aey !== 1'b1 || if2.afl !== 1'b0) begin n_errors++; $display("FAIL rst_thr2 got aey=%b afl=%b want 1 0", if2.aey, if2.afl); end
      rst = 1'b0;
      step();
      $display("test_reset done");
   endtask

   task automatic test_fill_drain();
      logic [7:0] exp;
      for (int i = 0; i < 4; i++) begin
         if0.wen = 1'b1; if0.wdt = 8'(8'h11 * (i + 1));
         step();
         n_checks++; if (if0.lvl !== 3'(i + 1)) begin n_errors++; $display("FAIL fill_lvl got %0d want %0d", if0.lvl, i + 1); end
         n_checks++; if (if0.afl !== (i + 1 >= 3)) begin n_errors++; $display("FAIL fill_afl lvl=%0d got %b want %b", i + 1, if0.afl, (i + 1 >= 3)); end
         n_checks++; if (if0.wfl !== (i == 3)) begin n_errors++; $display("FAIL fill_wfl lvl=%0d got %b want %b", i + 1, if0.wfl, (i == 3)); end
      end
      if0.wdt = 8'h55;
      step();
      if0.wen = 1'b0;
      n_checks++; if (if0.ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_set got %b want 1", if0.ovf); end
      n_checks++; if (if0.lvl !== 3'd4) begin n_errors++; $display("FAIL ovf_lvl got %0d want 4", if0.lvl); end
      for (int i = 0; i < 4; i++) begin
         exp = 8'(8'h11 * (i + 1));
         n_checks++; if (if0.rdt !== exp) begin n_errors++; $display("FAIL drain_rdt got %h want %h", if0.rdt, exp); end
         if0.ren = 1'b1;
         step();
         n_checks++; if (if0.lvl !== 3'(3 - i)) begin n_errors++; $display("FAIL drain_lvl got %0d want %0d", if0.lvl, 3 - i); end
      end
      if0.ren = 1'b0;
      n_checks++; if (if0.rey !== 1'b1 || if0.rdt !== 8'h00) begin n_errors++; $display("FAIL drain_empty got rey=%b rdt=%h want 1 00", if0.rey, if0.rdt); end
      pulse_clr0();
      $display("test_fill_drain done");
   endtask

   task automatic test_underflow();
      if0.ren = 1'b1; step(); if0.ren = 1'b0;
      n_checks++; if (if0.udf !== 1'b1) begin n_errors++; $display("FAIL udf_set got %b want 1", if0.udf); end
      n_checks++; if (if0.lvl !== 3'd0 || if0.rey !== 1'b1) begin n_errors++; $display("FAIL udf_lvl got lvl=%0d rey=%b want 0 1", if0.lvl, if0.rey); end
      if0.wen = 1'b1; if0.wdt = 8'hA5; step(); if0.wen = 1'b0;
      n_checks++; if (if0.rdt !== 8'hA5) begin n_errors++; $display("FAIL udf_fwft_rdt got %h want a5", if0.rdt); end
      n_checks++; if (if0.rey !== 1'b0 || if0.udf !== 1'b1) begin n_errors++; $display("FAIL udf_hold got rey=%b udf=%b want 0 1", if0.rey, if0.udf); end
      if0.ren = 1'b1; step(); if0.ren = 1'b0;
      n_checks++; if (if0.rey !== 1'b1) begin n_errors++; $display("FAIL udf_drain got rey=%b want 1", if0.rey); end
      pulse_clr0();
      $display("test_underflow done");
   endtask

   task automatic test_full_simul();
      logic [7:0] q[$];
      logic [7:0] v;
      for (int i = 0; i < 4; i++) begin
         v = 8'($urandom_range(0, 255));
         if0.wen = 1'b1; if0.wdt = v; step(); q.push_back(v);
      end
      if0.ren = 1'b1; if0.wdt = 8'($urandom_range(0, 255));
      n_checks++; if (if0.rdt !== q[0]) begin n_errors++; $display("FAIL fs_oldest got %h want %h", if0.rdt, q[0]); end
      step(); void'(q.pop_front());
      n_checks++; if (if0.lvl !== 3'd3 || if0.ovf !== 1'b1) begin n_errors++; $display("FAIL fs_drop got lvl=%0d ovf=%b want 3 1", if0.lvl, if0.ovf); end
      n_checks++; if (if0.rdt !== q[0]) begin n_errors++; $display("FAIL fs_next got %h want %h", if0.rdt, q[0]); end
      if0.wen = 1'b0; step(); void'(q.pop_front()); if0.wen = 1'b1;
      for (int c = 0; c < 20; c++) begin
         v = 8'($urandom_range(0, 255));
         if0.wdt = v;
         n_checks++; if (if0.rdt !== q[0]) begin n_errors++; $display("FAIL b2b_rdt cyc=%0d got %h want %h", c, if0.rdt, q[0]); end
         step(); void'(q.pop_front()); q.push_back(v);
         n_checks++; if (if0.lvl !== 3'd2) begin n_errors++; $display("FAIL b2b_lvl cyc=%0d got %0d want 2", c, if0.lvl); end
      end
      if0.wen = 1'b0; if0.ren = 1'b0;
      pulse_clr0();
      $display("test_full_simul done");
   endtask

   task automatic test_registered();
      if1.wen = 1'b1; if1.wdt = 8'h5A; step(); if1.wen = 1'b0;
      n_checks++; if (if1.rey !== 1'b0 || if1.rdt !== 8'h00) begin n_errors++; $display("FAIL reg_prewrite got rey=%b rdt=%h want 0 00", if1.rey, if1.rdt); end
      if1.ren = 1'b1; #1;
      n_checks++; if (if1.rdt !== 8'h00) begin n_errors++; $display("FAIL reg_rencyc got %h want 00", if1.rdt); end
      step(); if1.ren = 1'b0;
      n_checks++; if (if1.rdt !== 8'h5A || if1.rey !== 1'b1) begin n_errors++; $display("FAIL reg_load got rdt=%h rey=%b want 5a 1", if1.rdt, if1.rey); end
      step(); step();
      n_checks++; if (if1.rdt !== 8'h5A) begin n_errors++; $display("FAIL reg_hold got %h want 5a", if1.rdt); end
      if1.ren = 1'b1; step(); if1.ren = 1'b0;
      n_checks++; if (if1.rdt !== 8'h5A || if1.udf !== 1'b1) begin n_errors++; $display("FAIL reg_emptyread got rdt=%h udf=%b want 5a 1", if1.rdt, if1.udf); end
      if1.wen = 1'b1; if1.wdt = 8'h3C; step(); if1.wen = 1'b0;
      n_checks++; if (if1.rdt !== 8'h5A) begin n_errors++; $display("FAIL reg_wrhold got %h want 5a", if1.rdt); end
      if1.ren = 1'b1; step(); if1.ren = 1'b0;
      n_checks++; if (if1.rdt !== 8'h3C) begin n_errors++; $display("FAIL reg_second got %h want 3c", if1.rdt); end
      if1.clr = 1'b1; step(); if1.clr = 1'b0;
      n_checks++; if (if1.rdt !== 8'h00 || if1.udf !== 1'b0) begin n_errors++; $display("FAIL reg_clr got rdt=%h udf=%b want 00 0", if1.rdt, if1.udf); end
      $display("test_registered done");
   endtask

   task automatic test_clear();
      if0.wen = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if0.wdt = 8'(8'h10 + i); step();
      end
      if0.wen = 1'b0; if0.ren = 1'b1; step(); if0.ren = 1'b0;
      n_checks++; if (if0.lvl !== 3'd3 || if0.ovf !== 1'b1) begin n_errors++; $display("FAIL clr_pre got lvl=%0d ovf=%b want 3 1", if0.lvl, if0.ovf); end
      if0.clr = 1'b1; if0.wen = 1'b1; if0.wdt = 8'hEE; step(); if0.clr = 1'b0; if0.wen = 1'b0;
      n_checks++; if (if0.lvl !== 3'd0 || if0.rey !== 1'b1) begin n_errors++; $display("FAIL clr_lvl got lvl=%0d rey=%b want 0 1", if0.lvl, if0.rey); end
      n_checks++; if (if0.ovf !== 1'b0 || if0.rdt !== 8'h00) begin n_errors++; $display("FAIL clr_flags got ovf=%b rdt=%h want 0 00", if0.ovf, if0.rdt); end
      if0.ren = 1'b1; step(); if0.ren = 1'b0;
      if0.wen = 1'b1; if0.wdt = 8'h71; step(); step();
      #2; rst = 1'b1; #1;
      n_checks++; if (if0.lvl !== 3'd0 || if0.rey !== 1'b1) begin n_errors++; $display("FAIL arst_lvl got lvl=%0d rey=%b want 0 1", if0.lvl, if0.rey); end
      n_checks++; if (if0.udf !== 1'b0 || if0.afl !== 1'b0 || if0.aey !== 1'b1) begin n_errors++; $display("FAIL arst_flags got udf=%b afl=%b aey=%b want 0 0 1", if0.udf, if0.afl, if0.aey); end
      if0.wen = 1'b0; #2; rst = 1'b0;
      step();
      $display("test_clear done");
   endtask

   task automatic test_sweep();
      logic [15:0] q[$];
      logic [15:0] v, exp_rdt;
      logic        w, r, full_m, empty_m, ovf_m, udf_m;
      int          wp;
      ovf_m = 1'b0; udf_m = 1'b0;
      for (int i = 0; i < 16; i++) begin
         v = 16'($urandom_range(0, 65535));
         if2.wen = 1'b1; if2.wdt = v; step(); q.push_back(v);
         n_checks++; if (if2.afl !== (q.size() >= 14) || if2.aey !== (q.size() <= 2)) begin n_errors++; $display("FAIL sw_fill lvl=%0d got afl=%b aey=%b", q.size(), if2.afl, if2.aey); end
      end
      if2.wen = 1'b0; if2.ren = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (if2.rdt !== q[0]) begin n_errors++; $display("FAIL sw_drain got %h want %h", if2.rdt, q[0]); end
         step(); void'(q.pop_front());
         n_checks++; if (if2.afl !== (q.size() >= 14) || if2.aey !== (q.size() <= 2)) begin n_errors++; $display("FAIL sw_drthr lvl=%0d got afl=%b aey=%b", q.size(), if2.afl, if2.aey); end
      end
      if2.ren = 1'b0;
      for (int c = 0; c < 100; c++) begin
         wp = (c < 50) ? 75 : 25;
         w = ($urandom_range(0, 99) < wp);
         r = ($urandom_range(0, 99) < 100 - wp);
         v = 16'($urandom_range(0, 65535));
         if2.wen = w; if2.ren = r; if2.wdt = v;
         full_m = (q.size() == 16); empty_m = (q.size() == 0);
         ovf_m = ovf_m | (w & full_m);
         udf_m = udf_m | (r & empty_m);
         step();
         if (r && !empty_m) void'(q.pop_front());
         if (w && !full_m) q.push_back(v);
         exp_rdt = (q.size() != 0) ? q[0] : 16'h0;
         n_checks++;
         if (if2.lvl !== 5'(q.size()) || if2.rdt !== exp_rdt || if2.rey !== (q.size() == 0) || if2.wfl !== (q.size() == 16)
             || if2.afl !== (q.size() >= 14) || if2.aey !== (q.size() <= 2) || if2.ovf !== ovf_m || if2.udf !== udf_m) begin
            n_errors++;
            $display("FAIL sw_rand cyc=%0d got lvl=%0d rdt=%h rey=%b wfl=%b afl=%b aey=%b ovf=%b udf=%b want lvl=%0d rdt=%h ovf=%b udf=%b",
                     c, if2.lvl, if2.rdt, if2.rey, if2.wfl, if2.afl, if2.aey, if2.ovf, if2.udf, q.size(), exp_rdt, ovf_m, udf_m);
         end
      end
      if2.wen = 1'b0; if2.ren = 1'b0;
      $display("test_sweep done");
   endtask

   initial begin
      rst = 1'b1;
      if0.clr = 1'b0; if0.wen = 1'b0; if0.ren = 1'b0; if0.wdt = '0;
      if1.clr = 1'b0; if1.wen = 1'b0; if1.ren = 1'b0; if1.wdt = '0;
      if2.clr = 1'b0; if2.wen = 1'b0; if2.ren = 1'b0; if2.wdt = '0;
      test_reset();
      test_fill_drain();
      test_underflow();
      test_full_simul();
      test_registered();
      test_clear();
      if2.clr = 1'b1; step(); if2.clr = 1'b0;
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
